// File: rtl/lz77_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : lz77_pkg
//  Purpose  : Constants and FSM state encoding shared by the LZ77 compressor
//             and decompressor.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package lz77_pkg;

    // History window geometry. The window holds WINDOW_SIZE bytes, one less
    // than the address space, so index 2^12-1 is never used.
    localparam int unsigned WINDOW_SIZE          = 4095;
    localparam int unsigned WINDOW_ADDRESS_BITS  = 12;
    localparam int unsigned LENGTH_BITS          = 6;
    localparam int unsigned MINIMUM_MATCH_LENGTH = 3;

    // Token layout: flag + literal byte, or flag + offset + length.
    localparam int unsigned LITERAL_BITS       = 8;
    localparam int unsigned LITERAL_TOKEN_BITS = 1 + LITERAL_BITS;                            // 9
    localparam int unsigned MATCH_TOKEN_BITS   = 1 + WINDOW_ADDRESS_BITS + LENGTH_BITS;       // 19

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_FLAG  = 4'd1,
        ST_LIT   = 4'd2,
        ST_OFS   = 4'd3,
        ST_LEN   = 4'd4,
        ST_RD    = 4'd5,
        ST_EMIT  = 4'd6,
        ST_DONE  = 4'd7,
        ST_ERROR = 4'd8
    } lz77_state_e;

endpackage
`default_nettype wire

// File: rtl/lz77_window_ram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : lz77_window_ram
//  Purpose  : History window storage, one write port and one synchronous read
//             port, written so that tools map it onto block RAM.
//  Ports    : clk               - clock
//             wr_en/wr_addr/wr_data - write port
//             rd_en/rd_addr     - read request, data valid the next cycle
//             rd_data           - registered read data (holds between reads)
//  Revision : 1.0 - initial release
// ============================================================================
module lz77_window_ram
    import lz77_pkg::*;
#(
    parameter int DEPTH     = WINDOW_SIZE,
    parameter int ADDR_BITS = WINDOW_ADDRESS_BITS
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [7:0]           wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [7:0]           rd_data
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_data_q;

    // No reset: the contents are deliberately preserved and a reset-free
    // array is what lets the memory map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/lz77_decompressor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : lz77_decompressor
//  Purpose  : Serial LZ77 token decoder. Bits arrive MSB-first; literal tokens
//             are emitted directly, match tokens are copied out of a history
//             window one byte per two cycles.
//  Ports    : clk, rst_n (async, active-low)
//             start            - begin a stream (honoured in IDLE only)
//             busy/done/error  - stream status
//             inBit/inValid/inReady/inLast - serial token input
//             outData/outValid/outReady    - decoded byte output
//             bytesWritten     - output handshakes since reset
//  Revision : 1.0 - initial release
// ============================================================================
module lz77_decompressor
    import lz77_pkg::*;
#(
    parameter int windowSize         = WINDOW_SIZE,
    parameter int windowAddressBits  = WINDOW_ADDRESS_BITS,
    parameter int lengthBits         = LENGTH_BITS,
    parameter int minimumMatchLength = MINIMUM_MATCH_LENGTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    input  logic        inBit,
    input  logic        inValid,
    output logic        inReady,
    input  logic        inLast,
    output logic [7:0]  outData,
    output logic        outValid,
    input  logic        outReady,
    output logic [31:0] bytesWritten
);

    localparam int AW = windowAddressBits;
    localparam int LW = lengthBits;
    localparam int CW = windowAddressBits + 1;   // room for a full-window count

    localparam logic [CW-1:0] WS       = CW'(windowSize);
    localparam logic [LW-1:0] MIN_LEN  = LW'(minimumMatchLength);
    localparam logic [3:0]    LIT_LAST = 4'(LITERAL_BITS - 1);
    localparam logic [3:0]    OFS_LAST = 4'(windowAddressBits - 1);
    localparam logic [3:0]    LEN_LAST = 4'(lengthBits - 1);

    // Modular add for two in-window indices. Both operands are below
    // windowSize, so a single conditional subtract is enough.
    function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] a,
                                               input logic [AW-1:0] b);
        logic [CW-1:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= WS) begin
            s = s - WS;
        end
        return s[AW-1:0];
    endfunction

    lz77_state_e   state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    lit_q, lit_d;
    logic [AW-1:0] offset_q, offset_d;
    logic [LW-1:0] length_q, length_d;
    logic [AW-1:0] base_q, base_d;
    logic [LW-1:0] k_q, k_d;
    logic          last_q, last_d;
    logic          from_ram_q, from_ram_d;
    logic          out_valid_q, out_valid_d;
    logic [31:0]   bytes_written_q, bytes_written_d;
    logic [CW-1:0] chars_in_window_q, chars_in_window_d;
    logic [AW-1:0] oldest_q, oldest_d;

    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [7:0]    ram_rd_data;

    logic          bit_acc;
    logic [LW-1:0] len_shift;
    logic [CW-1:0] match_span;
    logic [LW-1:0] k_next;

    assign inReady  = (state_q == ST_FLAG) || (state_q == ST_LIT) ||
                      (state_q == ST_OFS)  || (state_q == ST_LEN);
    assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE) &&
                      (state_q != ST_ERROR);
    assign done     = (state_q == ST_DONE);
    assign error    = (state_q == ST_ERROR);
    assign outValid = out_valid_q;
    // The RAM output register holds its value until the next read, so it can
    // drive outData directly through a stall without an extra copy.
    assign outData  = from_ram_q ? ram_rd_data : lit_q;
    assign bytesWritten = bytes_written_q;

    assign bit_acc    = inValid && inReady;
    assign len_shift  = {length_q[LW-2:0], inBit};
    assign match_span = CW'(offset_q) + CW'(len_shift);
    assign k_next     = k_q + LW'(1);

    always_comb begin
        state_d           = state_q;
        bit_cnt_d         = bit_cnt_q;
        lit_d             = lit_q;
        offset_d          = offset_q;
        length_d          = length_q;
        base_d            = base_q;
        k_d               = k_q;
        last_d            = last_q;
        from_ram_d        = from_ram_q;
        out_valid_d       = out_valid_q;
        bytes_written_d   = bytes_written_q;
        chars_in_window_d = chars_in_window_q;
        oldest_d          = oldest_q;
        ram_wr_en         = 1'b0;
        ram_wr_addr       = oldest_q;
        ram_rd_en         = 1'b0;
        // Source index: base + offset + k, each step wrapping at windowSize.
        ram_rd_addr       = wrap_add(wrap_add(base_q, offset_q), AW'(k_q));

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_FLAG;
                    bit_cnt_d = 4'd0;
                end
            end

            ST_FLAG: begin
                if (bit_acc) begin
                    bit_cnt_d = 4'd0;
                    if (inLast) begin
                        state_d = ST_ERROR;       // a flag is never a final bit
                    end else if (inBit) begin
                        state_d = ST_LIT;
                    end else begin
                        state_d = ST_OFS;
                    end
                end
            end

            ST_LIT: begin
                if (bit_acc) begin
                    lit_d = {lit_q[6:0], inBit};
                    if (bit_cnt_q == LIT_LAST) begin
                        last_d      = inLast;
                        from_ram_d  = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = ST_EMIT;
                    end else if (inLast) begin
                        state_d = ST_ERROR;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end

            ST_OFS: begin
                if (bit_acc) begin
                    // Window cannot change during the token, so sampling the
                    // oldest pointer on the first offset bit fixes the base.
                    if (bit_cnt_q == 4'd0) begin
                        base_d = oldest_q;
                    end
                    offset_d = {offset_q[AW-2:0], inBit};
                    if (inLast) begin
                        state_d = ST_ERROR;
                    end else if (bit_cnt_q == OFS_LAST) begin
                        bit_cnt_d = 4'd0;
                        state_d   = ST_LEN;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end

            ST_LEN: begin
                if (bit_acc) begin
                    length_d = len_shift;
                    if (bit_cnt_q == LEN_LAST) begin
                        last_d = inLast;
                        k_d    = '0;
                        if ((len_shift < MIN_LEN) || (match_span > chars_in_window_q)) begin
                            state_d = ST_ERROR;
                        end else begin
                            state_d = ST_RD;
                        end
                    end else if (inLast) begin
                        state_d = ST_ERROR;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end

            ST_RD: begin
                ram_rd_en   = 1'b1;
                from_ram_d  = 1'b1;
                out_valid_d = 1'b1;
                state_d     = ST_EMIT;
            end

            ST_EMIT: begin
                if (outReady) begin
                    ram_wr_en       = 1'b1;
                    out_valid_d     = 1'b0;
                    bytes_written_d = bytes_written_q + 32'd1;
                    if (chars_in_window_q < WS) begin
                        ram_wr_addr       = wrap_add(oldest_q, chars_in_window_q[AW-1:0]);
                        chars_in_window_d = chars_in_window_q + CW'(1);
                    end else begin
                        ram_wr_addr = oldest_q;
                        oldest_d    = wrap_add(oldest_q, AW'(1));
                    end
                    bit_cnt_d = 4'd0;
                    if (from_ram_q && (k_next < length_q)) begin
                        k_d     = k_next;
                        state_d = ST_RD;
                    end else if (last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FLAG;
                    end
                end
            end

            ST_DONE:  state_d = ST_DONE;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_ERROR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            bit_cnt_q         <= 4'd0;
            lit_q             <= 8'd0;
            offset_q          <= '0;
            length_q          <= '0;
            base_q            <= '0;
            k_q               <= '0;
            last_q            <= 1'b0;
            from_ram_q        <= 1'b0;
            out_valid_q       <= 1'b0;
            bytes_written_q   <= 32'd0;
            chars_in_window_q <= '0;
            oldest_q          <= '0;
        end else begin
            state_q           <= state_d;
            bit_cnt_q         <= bit_cnt_d;
            lit_q             <= lit_d;
            offset_q          <= offset_d;
            length_q          <= length_d;
            base_q            <= base_d;
            k_q               <= k_d;
            last_q            <= last_d;
            from_ram_q        <= from_ram_d;
            out_valid_q       <= out_valid_d;
            bytes_written_q   <= bytes_written_d;
            chars_in_window_q <= chars_in_window_d;
            oldest_q          <= oldest_d;
        end
    end

    lz77_window_ram #(
        .DEPTH     (windowSize),
        .ADDR_BITS (windowAddressBits)
    ) u_window_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data (outData),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_lz77_decompressor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_lz77_decompressor
//  Purpose  : Self-checking bench for lz77_decompressor against a queue/array
//             reference model of the token rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lz77_decompressor;
    import lz77_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, start, inBit, inValid, inLast, outReady;
    logic        busy, done, error, inReady, outValid;
    logic [7:0]  outData;
    logic [31:0] bytesWritten;

    lz77_decompressor dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .error(error), .inBit(inBit), .inValid(inValid), .inReady(inReady),
        .inLast(inLast), .outData(outData), .outValid(outValid),
        .outReady(outReady), .bytesWritten(bytesWritten)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_lit;
        int unsigned val;
        int unsigned off;
        int unsigned len;
    } tok_t;

    tok_t          toks[$];
    byte unsigned  got_q[$];
    byte unsigned  exp_q[$];
    byte unsigned  win[WINDOW_SIZE];
    bit            exp_err;
    int            exp_chars;
    int            n_checks = 0;
    int            n_fail   = 0;
    bit            rdy_random = 0;
    bit            use_gaps   = 0;
    bit            abort_run  = 0;
    bit            hold_valid = 0;
    logic [7:0]    hold_data  = 8'd0;
    int            stall_at   = -1;
    int            stall_left = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output side: decide outReady, check held data during stalls, and
    // record every byte that will transfer on the coming rising edge.
    always begin
        @(negedge clk);
        if (rst_n && hold_valid) begin
            check("stall_valid", 32'(outValid), 32'd1);
            check("stall_data", 32'(outData), 32'(hold_data));
        end
        if (outValid && stall_at >= 0 && got_q.size() == stall_at) begin
            stall_left = 10;
            stall_at   = -1;
        end
        if (stall_left > 0) begin
            outReady = 1'b0;
            stall_left--;
        end else begin
            outReady = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        hold_valid = rst_n && outValid && !outReady;
        hold_data  = outData;
        if (rst_n && outValid && outReady) got_q.push_back(outData);
    end

    // Reference model: window as a plain array, indices by modulo arithmetic.
    task automatic model_put(input byte unsigned b, inout int oldest, inout int chars);
        exp_q.push_back(b);
        if (chars < WINDOW_SIZE) begin
            win[(oldest + chars) % WINDOW_SIZE] = b;
            chars++;
        end else begin
            win[oldest] = b;
            oldest = (oldest + 1) % WINDOW_SIZE;
        end
    endtask

    task automatic run_model();
        int oldest = 0;
        int chars  = 0;
        exp_q.delete();
        exp_err = 0;
        foreach (toks[t]) begin
            if (toks[t].is_lit) begin
                model_put(byte'(toks[t].val), oldest, chars);
            end else if (toks[t].len < MINIMUM_MATCH_LENGTH ||
                         int'(toks[t].off + toks[t].len) > chars) begin
                exp_err = 1;
                break;
            end else begin
                int base = oldest;
                for (int k = 0; k < int'(toks[t].len); k++) begin
                    model_put(win[(base + int'(toks[t].off) + k) % WINDOW_SIZE], oldest, chars);
                end
            end
        end
        exp_chars = chars;
    endtask

    function automatic tok_t lit_tok(input int unsigned v);
        tok_t t;
        t.is_lit = 1; t.val = v; t.off = 0; t.len = 0;
        return t;
    endfunction

    function automatic tok_t match_tok(input int unsigned off, input int unsigned len);
        tok_t t;
        t.is_lit = 0; t.val = 0; t.off = off; t.len = len;
        return t;
    endfunction

    task automatic send_bit(input bit b, input bit last);
        int waited = 0;
        bit sent   = 0;
        while (!sent && !abort_run) begin
            @(negedge clk);
            if (use_gaps && $urandom_range(0, 3) == 0) begin
                inValid = 1'b0;
            end else begin
                inValid = 1'b1;
                inBit   = b;
                inLast  = last;
                if (inReady) begin
                    sent = 1;
                end else begin
                    waited++;
                    if (waited > 2000) begin
                        check("inready_wait", 32'(inReady), 32'd1);
                        abort_run = 1;
                    end
                end
            end
        end
    endtask

    task automatic send_token(input tok_t t, input bit last);
        if (t.is_lit) begin
            send_bit(1'b1, 1'b0);
            for (int i = 7; i >= 0; i--) send_bit(t.val[i], last && i == 0);
        end else begin
            send_bit(1'b0, 1'b0);
            for (int i = 11; i >= 0; i--) send_bit(t.off[i], 1'b0);
            for (int i = 5; i >= 0; i--) send_bit(t.len[i], last && i == 0);
        end
    endtask

    task automatic do_reset(input bit check_outputs);
        @(negedge clk);
        #2;
        rst_n = 1'b0; start = 1'b0; inValid = 1'b0; inLast = 1'b0;
        #1;
        if (check_outputs) begin
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_error", 32'(error), 32'd0);
            check("rst_inready", 32'(inReady), 32'd0);
            check("rst_outvalid", 32'(outValid), 32'd0);
            check("rst_outdata", 32'(outData), 32'd0);
            check("rst_bytes", bytesWritten, 32'd0);
            check("rst_chars", 32'(dut.chars_in_window_q), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        got_q.delete();
        abort_run  = 0;
        stall_at   = -1;
        stall_left = 0;
    endtask

    task automatic start_stream();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic send_all(input bit with_last);
        foreach (toks[i]) send_token(toks[i], with_last && (i == toks.size() - 1));
        @(negedge clk); inValid = 1'b0; inLast = 1'b0;
    endtask

    task automatic finish_and_compare(input string name);
        int  bound = 400 + 30 * exp_q.size();
        int  c     = 0;
        while (c < bound && !(done || error)) begin
            @(negedge clk);
            c++;
        end
        check({name, ":terminal"}, 32'(done || error), 32'd1);
        repeat (3) @(negedge clk);
        check({name, ":error"}, 32'(error), 32'(exp_err));
        check({name, ":done"}, 32'(done), 32'(!exp_err));
        check({name, ":busy"}, 32'(busy), 32'd0);
        check({name, ":outvalid"}, 32'(outValid), 32'd0);
        check({name, ":bytes_written"}, bytesWritten, 32'(exp_q.size()));
        check({name, ":byte_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        check({name, ":chars"}, 32'(dut.chars_in_window_q), 32'(exp_chars));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({name, ":data"}, 32'(got_q[i]), 32'(exp_q[i]));
            if (got_q[i] != exp_q[i]) break;
        end
    endtask

    task automatic run_stream(input string name, input bit reset_first, input int stall_idx);
        if (reset_first) do_reset(0);
        stall_at = stall_idx;
        run_model();
        start_stream();
        send_all(1'b1);
        finish_and_compare(name);
    endtask

    task automatic gen_random(input int n);
        int chars = 0;
        toks.delete();
        for (int i = 0; i < n; i++) begin
            if (chars < 3 || $urandom_range(0, 9) < 6) begin
                toks.push_back(lit_tok($urandom_range(0, 255)));
                chars = (chars + 1 > WINDOW_SIZE) ? WINDOW_SIZE : chars + 1;
            end else begin
                int len = $urandom_range(3, (chars < 63) ? chars : 63);
                int off = $urandom_range(0, chars - len);
                toks.push_back(match_tok(off, len));
                chars = (chars + len > WINDOW_SIZE) ? WINDOW_SIZE : chars + len;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; inBit = 1'b0; inValid = 1'b0;
        inLast = 1'b0; outReady = 1'b1;

        do_reset(1);

        // Three literals, last one terminates the stream.
        toks.delete();
        toks.push_back(lit_tok(8'h41)); toks.push_back(lit_tok(8'h42)); toks.push_back(lit_tok(8'h43));
        run_stream("lit_abc", 1, -1);

        // Literals followed by a full-history copy.
        toks.push_back(match_tok(0, 3));
        run_stream("abcabc", 1, -1);

        // Ten-cycle stall on the first copied byte of a length-5 match.
        toks.delete();
        for (int i = 0; i < 5; i++) toks.push_back(lit_tok(8'h41 + i));
        toks.push_back(match_tok(0, 5));
        run_stream("stall_copy", 1, 5);

        // Illegal matches: too short, and reaching past the history.
        toks.delete();
        for (int i = 0; i < 3; i++) toks.push_back(lit_tok(8'h61 + i));
        toks.push_back(match_tok(0, 2));
        run_stream("err_short", 1, -1);
        toks.delete();
        for (int i = 0; i < 5; i++) toks.push_back(lit_tok(8'h70 + i));
        toks.push_back(match_tok(4, 3));
        run_stream("err_range", 1, -1);

        // inLast on the third bit of a literal token.
        toks.delete();
        do_reset(0);
        exp_q.delete(); exp_err = 1; exp_chars = 0;
        start_stream();
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b1);
        @(negedge clk); inValid = 1'b0; inLast = 1'b0;
        finish_and_compare("err_early_last");

        // Random streams with input gaps and output back-pressure.
        use_gaps = 1; rdy_random = 1;
        for (int r = 0; r < 3; r++) begin
            gen_random(30 + r * 10);
            run_stream("random", 1, -1);
        end
        use_gaps = 0; rdy_random = 0;

        // Reset in the middle of a copy, then restart with a single literal.
        toks.delete();
        for (int i = 0; i < 5; i++) toks.push_back(lit_tok(8'h31 + i));
        toks.push_back(match_tok(0, 5));
        do_reset(0);
        start_stream();
        send_all(1'b0);
        for (int c = 0; c < 200 && got_q.size() < 7; c++) @(negedge clk);
        check("midcopy_progress", 32'(got_q.size() >= 7), 32'd1);
        do_reset(1);
        toks.delete();
        toks.push_back(lit_tok(8'h5A));
        run_stream("restart_z", 0, -1);

        // Enough literals to wrap the window, then copy from the wrapped oldest.
        toks.delete();
        for (int i = 0; i < 4100; i++) toks.push_back(lit_tok($urandom_range(0, 255)));
        toks.push_back(match_tok(0, 3));
        run_stream("wrap_4100", 1, -1);
        check("wrap_src0", 32'(exp_q[4100]), 32'(toks[5].val));
        check("wrap_oldest", 32'(dut.oldest_q), 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
